// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end for a single shared combinational ALU.
// One registered issue stage feeds the ALU; each port owns one response slot.
module alu_share_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned OP_W     = 4,
  parameter bit          RR_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [OP_W-1:0]   req0_alu_op,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [OP_W-1:0]   req1_alu_op,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,

  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [OP_W-1:0]   alu_alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,

  output logic              busy
);

  typedef enum logic [1:0] {PIdle, PExec, PResp} port_state_e;

  logic [1:0]        req_valid;
  logic [1:0]        rsp_ready;
  logic [1:0]        elig;
  logic [1:0]        grant;
  logic              accept;
  logic [DATA_W-1:0] sel_op1;
  logic [DATA_W-1:0] sel_op2;
  logic [OP_W-1:0]   sel_op;

  port_state_e       state_q [2];
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_result_q [2];
  logic [1:0]        rsp_zero_q;
  logic              rr_q;

  logic              iss_valid_q;
  logic [DATA_W-1:0] iss_op1_q;
  logic [DATA_W-1:0] iss_op2_q;
  logic [OP_W-1:0]   iss_op_q;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A port is eligible only from PIdle, so a slot drained this cycle re-arms next cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] & (state_q[i] == PIdle);
    end
    grant = '0;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    sel_op1 = req0_op1;
    sel_op2 = req0_op2;
    sel_op  = req0_alu_op;
    if (grant[1]) begin
      sel_op1 = req1_op1;
      sel_op2 = req1_op2;
      sel_op  = req1_alu_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_op1_q   <= '0;
      iss_op2_q   <= '0;
      iss_op_q    <= '0;
      rr_q        <= RR_RESET;
    end else begin
      iss_valid_q <= accept;
      if (accept) begin
        iss_op1_q <= sel_op1;
        iss_op2_q <= sel_op2;
        iss_op_q  <= sel_op;
        // Pointer moves to the port that did not win.
        rr_q      <= grant[0];
      end
    end
  end

  assign alu_op1    = iss_valid_q ? iss_op1_q : '0;
  assign alu_op2    = iss_valid_q ? iss_op2_q : '0;
  assign alu_alu_op = iss_valid_q ? iss_op_q  : '0;

  // A port in PExec owns the issue register this cycle, so the ALU output is its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]      <= PIdle;
        rsp_result_q[i] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_zero_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (state_q[i])
          PIdle: begin
            if (grant[i]) state_q[i] <= PExec;
          end
          PExec: begin
            state_q[i]      <= PResp;
            rsp_result_q[i] <= alu_result;
            rsp_zero_q[i]   <= alu_zero;
            rsp_valid_q[i]  <= 1'b1;
          end
          PResp: begin
            if (rsp_ready[i]) begin
              state_q[i]     <= PIdle;
              rsp_valid_q[i] <= 1'b0;
            end
          end
          default: begin
            state_q[i]     <= PIdle;
            rsp_valid_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp_result_q[0];
  assign rsp1_result = rsp_result_q[1];
  assign rsp0_zero   = rsp_zero_q[0];
  assign rsp1_zero   = rsp_zero_q[1];

  assign busy = (state_q[0] != PIdle) | (state_q[1] != PIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small reference ALU on the alu_* side.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]  req0_alu_op, req1_alu_op;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_alu_op;
  logic        alu_zero;
  logic        busy;

  int n_vec;
  int n_err;

  alu_share_arbiter #(
    .DATA_W   (32),
    .OP_W     (4),
    .RR_RESET (1'b0)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op1    (req0_op1),
    .req0_op2    (req0_op2),
    .req0_alu_op (req0_alu_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op1    (req1_op1),
    .req1_op2    (req1_op2),
    .req1_alu_op (req1_alu_op),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_alu_op  (alu_alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .busy        (busy)
  );

  // Reference ALU: 0000 add, 0001 sub, 0111 sra, 1000 signed slt, others 0.
  always_comb begin
    case (alu_alu_op)
      4'b0000: alu_result = alu_op1 + alu_op2;
      4'b0001: alu_result = alu_op1 - alu_op2;
      4'b0111: alu_result = $signed(alu_op1) >>> alu_op2[4:0];
      4'b1000: alu_result = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op1 = '0; req0_op2 = '0; req0_alu_op = '0;
    req1_op1 = '0; req1_op2 = '0; req1_alu_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    idle_inputs();
    #2;

    // Reset values
    rst_n = 1'b0;
    sample();
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp0_result", rsp0_result, 0);
    check("rst_alu_op1", alu_op1, 0);
    check("rst_alu_op", alu_alu_op, 0);
    check("rst_busy", busy, 0);
    do_reset();

    // Single SUB on port 0, 2-cycle latency
    req0_valid = 1'b1; req0_op1 = 32'd5; req0_op2 = 32'd3; req0_alu_op = 4'b0001;
    sample();
    check("t1_req0_ready", req0_ready, 1);
    next_cycle();
    req0_valid = 1'b0;
    sample();
    check("t1_alu_op1", alu_op1, 32'd5);
    check("t1_alu_op", alu_alu_op, 4'b0001);
    check("t1_rsp0_early", rsp0_valid, 0);
    check("t1_busy", busy, 1);
    next_cycle();
    rsp0_ready = 1'b1;
    sample();
    check("t1_rsp0_valid", rsp0_valid, 1);
    check("t1_rsp0_result", rsp0_result, 32'd2);
    check("t1_rsp0_zero", rsp0_zero, 0);
    next_cycle();

    // Pointer now at port 1: contested grant goes to port 1, then port 0
    req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd1; req0_alu_op = 4'b0000;
    req1_valid = 1'b1; req1_op1 = 32'd9; req1_op2 = 32'd4; req1_alu_op = 4'b0001;
    rsp1_ready = 1'b1;
    sample();
    check("rr_grant_p1", {req1_ready, req0_ready}, 2'b10);
    next_cycle();
    req1_valid = 1'b0;
    sample();
    check("rr_then_p0", {req1_ready, req0_ready}, 2'b01);
    next_cycle();
    req0_valid = 1'b0;
    sample();
    check("rr_rsp1_valid", rsp1_valid, 1);
    check("rr_rsp1_result", rsp1_result, 32'd5);
    next_cycle();
    next_cycle();
    sample();
    check("rr_drain_busy", busy, 0);

    // Simultaneous requests after reset: port 0 first, both results at T+3
    do_reset();
    req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd1; req0_alu_op = 4'b0000;
    req1_valid = 1'b1; req1_op1 = 32'd7; req1_op2 = 32'd7; req1_alu_op = 4'b0001;
    sample();
    check("t2_grant_T", {req1_ready, req0_ready}, 2'b01);
    next_cycle();
    req0_valid = 1'b0;
    sample();
    check("t2_grant_T1", {req1_ready, req0_ready}, 2'b10);
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    sample();
    check("t2_rsp0_valid", rsp0_valid, 1);
    check("t2_rsp0_result", rsp0_result, 32'd2);
    check("t2_rsp0_zero", rsp0_zero, 0);
    check("t2_rsp1_valid", rsp1_valid, 1);
    check("t2_rsp1_result", rsp1_result, 32'd0);
    check("t2_rsp1_zero", rsp1_zero, 1);
    next_cycle();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    next_cycle();

    // Continuous requests on both ports: grants 0,1,-,0,1,-,...
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op1 = 32'd2; req0_op2 = 32'd3; req0_alu_op = 4'b0000;
    req1_valid = 1'b1; req1_op1 = 32'd9; req1_op2 = 32'd4; req1_alu_op = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      sample();
      check("t3_grant", {req1_ready, req0_ready},
            (c % 3 == 0) ? 2'b01 : ((c % 3 == 1) ? 2'b10 : 2'b00));
      if (c % 3 == 2) begin
        check("t3_rsp0_valid", rsp0_valid, 1);
        check("t3_rsp0_result", rsp0_result, 32'd5);
      end
      if (c % 3 == 0 && c > 0) begin
        check("t3_rsp1_valid", rsp1_valid, 1);
        check("t3_rsp1_result", rsp1_result, 32'd5);
      end
      next_cycle();
    end
    idle_inputs();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) next_cycle();

    // Backpressure on port 0 must not stall port 1
    do_reset();
    rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op1 = 32'h8000_0000; req0_op2 = 32'd4; req0_alu_op = 4'b0111;
    req1_valid = 1'b1; req1_op1 = 32'hFFFF_FFFF; req1_op2 = 32'd1; req1_alu_op = 4'b1000;
    for (int c = 0; c < 8; c++) begin
      sample();
      check("t4_req1_ready", req1_ready, (c % 3 == 1) ? 1 : 0);
      if (c >= 2 && c <= 6) begin
        check("t4_rsp0_valid", rsp0_valid, 1);
        check("t4_rsp0_result", rsp0_result, 32'hF800_0000);
        check("t4_req0_ready", req0_ready, 0);
      end
      if (c % 3 == 0 && c > 0) begin
        check("t4_rsp1_valid", rsp1_valid, 1);
        check("t4_rsp1_slt", rsp1_result, 32'd1);
      end
      next_cycle();
    end
    idle_inputs();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) next_cycle();

    // Reset while the issue register holds an op
    do_reset();
    req0_valid = 1'b1; req0_op1 = 32'd4; req0_op2 = 32'd4; req0_alu_op = 4'b0000;
    next_cycle();
    req0_valid = 1'b0;
    sample();
    check("t5_issue_live", alu_op1, 32'd4);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rsp0", rsp0_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_alu_op1", alu_op1, 0);
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      check("t5_no_rsp0", rsp0_valid, 0);
      check("t5_no_busy", busy, 0);
      next_cycle();
    end

    // Undefined opcode returns 0 with zero flag set
    req1_valid = 1'b1; req1_op1 = 32'd3; req1_op2 = 32'd4; req1_alu_op = 4'b1111;
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    sample();
    check("t6_undef_valid", rsp1_valid, 1);
    check("t6_undef_result", rsp1_result, 32'd0);
    check("t6_undef_zero", rsp1_zero, 1);
    rsp1_ready = 1'b1;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
